seq_pipe_add4_sched: RTL and testbench

Two-requester scheduler wrapped around a 2-stage pipelined 4-operand adder. Two clients each submit a 4-operand add request over a val/rdy interface. The block arbitrates between them round-robin and issues at most one request per cycle into the shared pipeline. Each result returns on a single val/rdy response port, tagged with the requester ID, with full backpressure and no loss or duplication.

---
 rtl/seq_pipe_add4_sched_if.sv | 42 ++++
 rtl/seq_pipe_add4_sched.sv | 133 +++++++++++++
 tb/tb_seq_pipe_add4_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pipe_add4_sched_if.sv
// Request/response bundle for the two-client pipelined 4-operand adder scheduler.
// The master modport is the client/consumer side; the slave modport is the scheduler.
interface seq_pipe_add4_sched_if #(
  parameter int unsigned NBITS = 8
);

  logic                 req0_val;
  logic                 req0_rdy;
  logic [4*NBITS-1:0]   req0_msg;

  logic                 req1_val;
  logic                 req1_rdy;
  logic [4*NBITS-1:0]   req1_msg;

  logic                 resp_val;
  logic                 resp_rdy;
  logic                 resp_id;
  logic [NBITS-1:0]     resp_sum01;
  logic [NBITS-1:0]     resp_sum23;
  logic [NBITS-1:0]     resp_sum;

  logic                 busy;

  modport master (
    output req0_val, req0_msg,
    output req1_val, req1_msg,
    output resp_rdy,
    input  req0_rdy, req1_rdy,
    input  resp_val, resp_id, resp_sum01, resp_sum23, resp_sum,
    input  busy
  );

  modport slave (
    input  req0_val, req0_msg,
    input  req1_val, req1_msg,
    input  resp_rdy,
    output req0_rdy, req1_rdy,
    output resp_val, resp_id, resp_sum01, resp_sum23, resp_sum,
    output busy
  );

endinterface

// File: rtl/seq_pipe_add4_sched.sv
// Round-robin two-requester scheduler feeding a 2-stage pipelined 4-operand adder.
// X0 holds operands, X1 holds pair sums; the final add is combinational on X1.
module seq_pipe_add4_sched #(
  parameter int unsigned NBITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seq_pipe_add4_sched_if.slave  bus
);

  localparam int unsigned MSGW = 4 * NBITS;

  // Stage X0
  logic              val0;
  logic              id0;
  logic [NBITS-1:0]  in0_x0;
  logic [NBITS-1:0]  in1_x0;
  logic [NBITS-1:0]  in2_x0;
  logic [NBITS-1:0]  in3_x0;
  logic [NBITS-1:0]  sum01_x0;
  logic [NBITS-1:0]  sum23_x0;

  // Stage X1
  logic              val1;
  logic              id1;
  logic [NBITS-1:0]  sum01_x1;
  logic [NBITS-1:0]  sum23_x1;

  // Scheduling
  logic              prio;
  logic              prio_next;
  logic              adv0;
  logic              adv1;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [MSGW-1:0]   sel_msg;

  // Stall chain: a stage may load whenever its successor can take its contents.
  always_comb begin
    adv1 = 1'b0;
    adv0 = 1'b0;
    adv1 = !val1 || bus.resp_rdy;
    adv0 = !val0 || adv1;
  end

  // Grant depends only on current request valids and the registered pointer.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    sel_msg = '0;
    grant0  = bus.req0_val && (!bus.req1_val || !prio);
    grant1  = bus.req1_val && (!bus.req0_val ||  prio);
    sel_msg = grant1 ? bus.req1_msg : bus.req0_msg;
  end

  // Ready is held low while reset is asserted so nothing is handshaken into a clearing pipe.
  always_comb begin
    bus.req0_rdy = 1'b0;
    bus.req1_rdy = 1'b0;
    xfer         = 1'b0;
    bus.req0_rdy = reset_n && adv0 && grant0;
    bus.req1_rdy = reset_n && adv0 && grant1;
    xfer         = bus.req0_rdy || bus.req1_rdy;
  end

  // Pointer moves to the requester that was not just served, only on an accepted transfer.
  always_comb begin
    prio_next = prio;
    if (xfer) begin
      prio_next = grant0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else begin
      prio <= prio_next;
    end
  end

  // X0 register: loads the granted request, or a bubble when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val0   <= 1'b0;
      id0    <= 1'b0;
      in0_x0 <= '0;
      in1_x0 <= '0;
      in2_x0 <= '0;
      in3_x0 <= '0;
    end else if (adv0) begin
      val0   <= grant0 || grant1;
      id0    <= grant1;
      in0_x0 <= sel_msg[0*NBITS +: NBITS];
      in1_x0 <= sel_msg[1*NBITS +: NBITS];
      in2_x0 <= sel_msg[2*NBITS +: NBITS];
      in3_x0 <= sel_msg[3*NBITS +: NBITS];
    end
  end

  always_comb begin
    sum01_x0 = '0;
    sum23_x0 = '0;
    sum01_x0 = NBITS'(in0_x0 + in1_x0);
    sum23_x0 = NBITS'(in2_x0 + in3_x0);
  end

  // X1 register: captures pair sums; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val1     <= 1'b0;
      id1      <= 1'b0;
      sum01_x1 <= '0;
      sum23_x1 <= '0;
    end else if (adv1) begin
      val1     <= val0;
      id1      <= id0;
      sum01_x1 <= sum01_x0;
      sum23_x1 <= sum23_x0;
    end
  end

  always_comb begin
    bus.resp_val   = val1;
    bus.resp_id    = id1;
    bus.resp_sum01 = sum01_x1;
    bus.resp_sum23 = sum23_x1;
    bus.resp_sum   = NBITS'(sum01_x1 + sum23_x1);
    bus.busy       = val0 || val1;
  end

endmodule

// File: tb/tb_seq_pipe_add4_sched.sv
// Directed bench for seq_pipe_add4_sched: reset, latency, wrap, contention,
// backpressure, pointer hold and asynchronous reset mid-flight.
module tb_seq_pipe_add4_sched;

  localparam int unsigned NB = 8;
  localparam int unsigned MW = 4 * NB;
  localparam int unsigned RW = 3 * NB + 2;

  typedef logic [RW-1:0] resp_t;
  typedef logic [MW-1:0] msg_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_pipe_add4_sched_if #(.NBITS(NB)) bus ();

  seq_pipe_add4_sched #(.NBITS(NB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic resp_t got_resp();
    return {bus.resp_val, bus.resp_id, bus.resp_sum01, bus.resp_sum23, bus.resp_sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b0;
    bus.req0_msg = '0;
    bus.req1_msg = '0;
    bus.resp_rdy = 1'b1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.req0_val = 1'b1;
    bus.req1_val = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (got_resp() !== resp_t'(0)) begin
      errors++; $display("FAIL reset_resp: got %h want 0", got_resp());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if ({bus.req0_rdy, bus.req1_rdy} !== 2'b00) begin
      errors++; $display("FAIL reset_rdy: got %b%b want 00", bus.req0_rdy, bus.req1_rdy);
    end
    drive_idle();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bus.req0_val = 1'b1;
    bus.req0_msg = 32'h04030201;
    #1;
    checks++;
    if (bus.req0_rdy !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_accept: rdy0=%b busy=%b want rdy0=1 busy=0", bus.req0_rdy, bus.busy);
    end
    tick();
    bus.req0_val = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.resp_val !== 1'b0) begin
      errors++; $display("FAIL single_x0: busy=%b resp_val=%b want busy=1 resp_val=0", bus.busy, bus.resp_val);
    end
    tick();
    checks++;
    if (got_resp() !== {1'b1, 1'b0, 8'd3, 8'd7, 8'd10}) begin
      errors++; $display("FAIL single_resp: got %h want %h", got_resp(), {1'b1, 1'b0, 8'd3, 8'd7, 8'd10});
    end
    tick();
    checks++;
    if (bus.resp_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: resp_val=%b busy=%b want 0 0", bus.resp_val, bus.busy);
    end
  endtask

  task automatic test_wrap();
    bus.req1_val = 1'b1;
    bus.req1_msg = 32'h01FF64C8;
    #1;
    checks++;
    if ({bus.req0_rdy, bus.req1_rdy} !== 2'b01) begin
      errors++; $display("FAIL wrap_rdy: got %b%b want 01", bus.req0_rdy, bus.req1_rdy);
    end
    tick();
    bus.req1_val = 1'b0;
    tick();
    checks++;
    if (got_resp() !== {1'b1, 1'b1, 8'd44, 8'd0, 8'd44}) begin
      errors++; $display("FAIL wrap_resp: got %h want %h", got_resp(), {1'b1, 1'b1, 8'd44, 8'd0, 8'd44});
    end
    tick();
    checks++;
    if (bus.resp_val !== 1'b0) begin
      errors++; $display("FAIL wrap_drain: resp_val=%b want 0", bus.resp_val);
    end
  endtask

  task automatic test_contention();
    msg_t  r0_tab [3] = '{32'h04030201, 32'h10100A05, 32'h80808080};
    msg_t  r1_tab [3] = '{32'h01FF64C8, 32'h05060708, 32'h7F7F0101};
    resp_t exp_tab [6] = '{
      {1'b1, 1'b0, 8'd3,  8'd7,   8'd10},
      {1'b1, 1'b1, 8'd44, 8'd0,   8'd44},
      {1'b1, 1'b0, 8'd15, 8'd32,  8'd47},
      {1'b1, 1'b1, 8'd15, 8'd11,  8'd26},
      {1'b1, 1'b0, 8'd0,  8'd0,   8'd0},
      {1'b1, 1'b1, 8'd2,  8'd254, 8'd0}
    };
    logic [1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1;
        bus.req0_msg = r0_tab[c/2];
        bus.req1_msg = r1_tab[c/2];
      end else begin
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
      end
      #1;
      if (c < 6) begin
        exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
        checks++;
        if ({bus.req0_rdy, bus.req1_rdy} !== exp_rdy) begin
          errors++; $display("FAIL contention_grant c%0d: got %b%b want %b", c, bus.req0_rdy, bus.req1_rdy, exp_rdy);
        end
      end
      checks++;
      if (c >= 2) begin
        if (got_resp() !== exp_tab[c-2]) begin
          errors++; $display("FAIL contention_resp c%0d: got %h want %h", c, got_resp(), exp_tab[c-2]);
        end
      end else if (bus.resp_val !== 1'b0) begin
        errors++; $display("FAIL contention_early c%0d: resp_val=%b want 0", c, bus.resp_val);
      end
      tick();
    end
    checks++;
    if (bus.resp_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL contention_drain: resp_val=%b busy=%b want 0 0", bus.resp_val, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    msg_t  b_tab [4] = '{32'h01020304, 32'h11111111, 32'hF0F00F0F, 32'h0A141E28};
    resp_t e_tab [4] = '{
      {1'b1, 1'b0, 8'd7,  8'd3,   8'd10},
      {1'b1, 1'b0, 8'd34, 8'd34,  8'd68},
      {1'b1, 1'b0, 8'd30, 8'd224, 8'd254},
      {1'b1, 1'b0, 8'd70, 8'd30,  8'd100}
    };
    logic cv   [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int   cm   [10] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
    logic crr  [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic crdy [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int   cres [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req0_val = cv[c];
      bus.req0_msg = b_tab[cm[c]];
      bus.resp_rdy = crr[c];
      #1;
      checks++;
      if (bus.req0_rdy !== crdy[c]) begin
        errors++; $display("FAIL bp_rdy c%0d: got %b want %b", c, bus.req0_rdy, crdy[c]);
      end
      checks++;
      if (cres[c] >= 0) begin
        if (got_resp() !== e_tab[cres[c]]) begin
          errors++; $display("FAIL bp_resp c%0d: got %h want %h", c, got_resp(), e_tab[cres[c]]);
        end
      end else if (bus.resp_val !== 1'b0) begin
        errors++; $display("FAIL bp_noresp c%0d: resp_val=%b want 0", c, bus.resp_val);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_busy: got %b want 0", bus.busy);
    end
    drive_idle();
  endtask

  task automatic test_priority_hold();
    msg_t  q_tab [5] = '{32'h00000001, 32'h02020202, 32'h03030303, 32'h05050505, 32'h09090909};
    resp_t e_tab [5] = '{
      {1'b1, 1'b0, 8'd1,  8'd0,  8'd1},
      {1'b1, 1'b1, 8'd4,  8'd4,  8'd8},
      {1'b1, 1'b0, 8'd6,  8'd6,  8'd12},
      {1'b1, 1'b1, 8'd10, 8'd10, 8'd20},
      {1'b1, 1'b0, 8'd18, 8'd18, 8'd36}
    };
    logic       v0   [13] = '{1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0};
    int         m0   [13] = '{0, 0, 0, 0, 2, 0, 4, 4, 4, 4, 0, 0, 0};
    logic       v1   [13] = '{0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int         m1   [13] = '{0, 0, 0, 1, 0, 3, 3, 3, 3, 0, 0, 0, 0};
    logic       rr   [13] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [1:0] erdy [13] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00,
                              2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    int         eres [13] = '{-1, -1, 0, -1, -1, 1, 1, 1, 1, 2, 3, 4, -1};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.req0_val = v0[c];
      bus.req0_msg = q_tab[m0[c]];
      bus.req1_val = v1[c];
      bus.req1_msg = q_tab[m1[c]];
      bus.resp_rdy = rr[c];
      #1;
      checks++;
      if ({bus.req0_rdy, bus.req1_rdy} !== erdy[c]) begin
        errors++; $display("FAIL prio_rdy c%0d: got %b%b want %b", c, bus.req0_rdy, bus.req1_rdy, erdy[c]);
      end
      checks++;
      if (eres[c] >= 0) begin
        if (got_resp() !== e_tab[eres[c]]) begin
          errors++; $display("FAIL prio_resp c%0d: got %h want %h", c, got_resp(), e_tab[eres[c]]);
        end
      end else if (bus.resp_val !== 1'b0) begin
        errors++; $display("FAIL prio_noresp c%0d: resp_val=%b want 0", c, bus.resp_val);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.resp_rdy = 1'b0;
    bus.req0_val = 1'b1;
    bus.req0_msg = 32'hAAAAAAAA;
    tick();
    bus.req0_msg = 32'h55555555;
    tick();
    bus.req1_val = 1'b1;
    bus.req1_msg = 32'h02020202;
    #1;
    checks++;
    if ({bus.resp_val, bus.busy, bus.req0_rdy, bus.req1_rdy} !== 4'b1100) begin
      errors++; $display("FAIL mid_full: val/busy/rdy0/rdy1 got %b%b%b%b want 1100",
                         bus.resp_val, bus.busy, bus.req0_rdy, bus.req1_rdy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (got_resp() !== resp_t'(0) || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_async_resp: resp %h busy %b want 0 0", got_resp(), bus.busy);
    end
    checks++;
    if ({bus.req0_rdy, bus.req1_rdy} !== 2'b00) begin
      errors++; $display("FAIL mid_async_rdy: got %b%b want 00", bus.req0_rdy, bus.req1_rdy);
    end
    tick();
    tick();
    reset_n = 1'b1;
    bus.resp_rdy = 1'b1;
    bus.req0_msg = 32'h01010101;
    #1;
    checks++;
    if ({bus.req0_rdy, bus.req1_rdy} !== 2'b10 || bus.resp_val !== 1'b0) begin
      errors++; $display("FAIL mid_regrant: rdy %b%b resp_val %b want 10 0", bus.req0_rdy, bus.req1_rdy, bus.resp_val);
    end
    tick();
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b0;
    #1;
    checks++;
    if (bus.resp_val !== 1'b0) begin
      errors++; $display("FAIL mid_stale: resp_val=%b want 0", bus.resp_val);
    end
    tick();
    checks++;
    if (got_resp() !== {1'b1, 1'b0, 8'd2, 8'd2, 8'd4}) begin
      errors++; $display("FAIL mid_resp: got %h want %h", got_resp(), {1'b1, 1'b0, 8'd2, 8'd2, 8'd4});
    end
    tick();
    checks++;
    if (bus.resp_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_drain: resp_val=%b busy=%b want 0 0", bus.resp_val, bus.busy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_priority_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
